alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage directly downstream of the 32-bit bitwise/arith units (NOR32bit etc.).
//  Captures the selected unit result plus op tag, derives zero/negative flags, and presents it
//  to writeback through a 2-entry skid buffer with valid/ready handshake. Counts retired results.
// PARAMETERS
//  WIDTH     32  datapath width of result and flag logic
//  OPW       3   width of op tag carried alongside result
//  CNTW      16  width of retired-result counter (wraps)
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      upstream result valid
//  in_ready   out  1      stage can accept (registered)
//  inC        in   WIDTH  result word from upstream unit (e.g. NOR32bit outC)
//  in_op      in   OPW    op tag of inC
//  out_valid  out  1      outC/flags valid
//  out_ready  in   1      downstream accepts
//  outC       out  WIDTH  registered result
//  out_op     out  OPW    registered op tag
//  out_zero   out  1      outC == 0
//  out_neg    out  1      outC[WIDTH-1]
//  retired    out  CNTW   count of output transfers
// BEHAVIOUR
//  - Clocking: one clock clk; reset rst is synchronous, active-high.
//  - Reset: out_valid=0, outC=0, out_op=0, out_zero=0, out_neg=0, retired=0, state=EMPTY,
//    in_ready=1 first cycle after rst deasserts (0 while rst high). Reset mid-op flushes both entries.
//  - Transfer in = in_valid&in_ready; transfer out = out_valid&out_ready.
//  - States: EMPTY (no data), ONE (main reg valid), TWO (main + skid valid).
//    EMPTY: in -> ONE.  ONE: in&!out -> TWO; !in&out -> EMPTY; in&out -> ONE (main reloads).
//    TWO: out -> ONE (skid moves to main); in is impossible (in_ready=0).
//  - in_ready registered: 1 in EMPTY/ONE, 0 in TWO. No combinational in_ready<-out_ready path.
//  - Latency: accepted word appears on outC the next cycle when stage was EMPTY, or ONE with out.
//  - Flags computed from incoming word at capture, stored with it (skid holds its own flags).
//  - Order preserved strictly FIFO; no drops, no duplicates.
//  - out_valid=0 => outC/flags hold last value (not cleared) except after reset.
//  - retired increments by 1 per output transfer; 2^CNTW-1 wraps to 0.
//  - in_valid while in_ready=0: ignored, no state change; upstream must hold.
// CONFIGURATION
//  Macro ALU_RESULT_PARITY_EN:
//   defined: extra output out_par (1 bit) = ^outC, captured and skidded with word; reset 0.
//   undefined: port out_par absent; no parity logic.
// TESTING
//  1 rst 2 cycles -> out_valid=0, outC=0, retired=0; in_ready=1 cycle after release.
//  2 inC=32'h0000_0000 op=3'd4, out_ready=1 -> next cycle outC=0, out_zero=1, out_neg=0, retired=1.
//  3 out_ready=0; push 32'h8000_0001, 32'h1234_5678 -> in_ready=0 after 2nd; release out_ready ->
//    outputs in order, first out_neg=1, in_ready=1 again one cycle after skid drains.
//  4 in_valid=out_ready=1 continuous 100 words -> one word/cycle, no bubble, retired=100.
//  5 state TWO, assert rst 1 cycle -> both entries flushed, out_valid=0 next cycle, retired=0.
//  6 CNTW=4, 17 transfers -> retired=1 (wrap); with ALU_RESULT_PARITY_EN, inC=32'h7 -> out_par=1.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the 32-bit logic/arith units.
// Captures the result word and its op tag, derives zero/negative flags at capture,
// and hands results to writeback through a 2-entry skid buffer (valid/ready).
// in_ready is registered, so there is no combinational path from out_ready.
// Counts output transfers in a wrapping counter.
// Optional feature: define ALU_RESULT_PARITY_EN to add out_par (= ^outC), which is
// captured and skidded together with its word.
module alu_result_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OPW   = 3,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inC,
   input  logic [OPW-1:0]   in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] outC,
   output logic [OPW-1:0]   out_op,
   output logic             out_zero,
   output logic             out_neg,
`ifdef ALU_RESULT_PARITY_EN
   output logic             out_par,
`endif
   output logic [CNTW-1:0]  retired
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   // One buffered result: word, tag and the flags derived when it was captured.
   typedef struct packed {
      logic [WIDTH-1:0] c;
      logic [OPW-1:0]   op;
      logic             z;
      logic             n;
`ifdef ALU_RESULT_PARITY_EN
      logic             p;
`endif
   } entry_t;

   state_t          state_q, state_d;
   entry_t          main_q, main_d;
   entry_t          skid_q, skid_d;
   entry_t          in_entry;
   logic            in_ready_q, in_ready_d;
   logic [CNTW-1:0] retired_q, retired_d;
   logic            in_xfer;
   logic            out_xfer;

   // Build the incoming entry; flags are fixed here and travel with the word.
   always_comb begin
      in_entry    = '0;
      in_entry.c  = inC;
      in_entry.op = in_op;
      in_entry.z  = (inC == '0);
      in_entry.n  = inC[WIDTH-1];
`ifdef ALU_RESULT_PARITY_EN
      in_entry.p  = ^inC;
`endif
   end

   // Next-state, data movement and counter update for the skid buffer.
   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      skid_d    = skid_q;
      retired_d = retired_q;
      in_xfer   = in_valid & in_ready_q;
      out_xfer  = (state_q != EMPTY) & out_ready;

      unique case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               main_d  = in_entry;
               state_d = ONE;
            end
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               skid_d  = in_entry;
               state_d = TWO;
            end else if (!in_xfer && out_xfer) begin
               state_d = EMPTY;
            end else if (in_xfer && out_xfer) begin
               main_d  = in_entry;
            end
         end
         TWO: begin
            // in_ready is low here, so only a drain of the main entry can happen.
            if (out_xfer) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (out_xfer) begin
         retired_d = retired_q + CNTW'(1);
      end

      // Ready for the next cycle depends only on where the buffer is going.
      in_ready_d = (state_d != TWO);
   end

   // State, entries, ready and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
         retired_q  <= retired_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign outC      = main_q.c;
   assign out_op    = main_q.op;
   assign out_zero  = main_q.z;
   assign out_neg   = main_q.n;
`ifdef ALU_RESULT_PARITY_EN
   assign out_par   = main_q.p;
`endif
   assign retired   = retired_q;

endmodule
